if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 109 ++++++++++
 tb/tb_if_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage: PC register, next-PC select, IF/ID register.
// Options  : define IF_PERF_CNT_EN to build the fetch/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PC_Write,
  input  logic        IF_Write,
  input  logic [1:0]  addrSel,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] InstrIn,
  output logic [31:0] InstrAddr,
  output logic [31:0] InstrID,
  output logic [31:0] PCPlus4ID,
  output logic        ValidID,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  localparam logic [1:0]  c_SEL_SEQ    = 2'b00;
  localparam logic [1:0]  c_SEL_JUMP   = 2'b01;
  localparam logic [1:0]  c_SEL_BRANCH = 2'b10;
  localparam logic [31:0] c_WORD_MASK  = 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc_plus4_id;
  logic        r_valid_id;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_next_pc;

  assign w_pc_plus4    = r_pc + 32'd4;
  // Jump target comes from the instruction already latched in IF/ID.
  assign w_jump_target = {r_pc_plus4_id[31:28], r_instr_id[25:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (addrSel)
      c_SEL_SEQ:    w_next_pc = w_pc_plus4;
      c_SEL_JUMP:   w_next_pc = w_jump_target;
      c_SEL_BRANCH: w_next_pc = BranchAddr & c_WORD_MASK;
      default:      w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
    end else if (PC_Write) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_instr_id    <= 32'h0000_0000;
      r_pc_plus4_id <= 32'h0000_0000;
      r_valid_id    <= 1'b0;
    end else if (IF_Write) begin
      r_instr_id    <= InstrIn;
      r_pc_plus4_id <= w_pc_plus4;
      r_valid_id    <= 1'b1;
    end
  end

  assign InstrAddr = r_pc;
  assign InstrID   = r_instr_id;
  assign PCPlus4ID = r_pc_plus4_id;
  assign ValidID   = r_valid_id;

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  // Both counters saturate rather than wrap.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fetch_count <= 32'h0000_0000;
      r_stall_count <= 32'h0000_0000;
    end else begin
      if (IF_Write && (r_fetch_count != c_CNT_MAX)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (!PC_Write && !IF_Write && (r_stall_count != c_CNT_MAX)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign FetchCount = r_fetch_count;
  assign StallCount = r_stall_count;
`else
  assign FetchCount = 32'h0000_0000;
  assign StallCount = 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage (honours IF_PERF_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic        Clk;
  logic        Rst;
  logic        PC_Write;
  logic        IF_Write;
  logic [1:0]  addrSel;
  logic [31:0] BranchAddr;
  logic [31:0] InstrIn;
  logic [31:0] InstrAddr;
  logic [31:0] InstrID;
  logic [31:0] PCPlus4ID;
  logic        ValidID;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;

  int          tests;
  int          fails;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .PC_Write   (PC_Write),
    .IF_Write   (IF_Write),
    .addrSel    (addrSel),
    .BranchAddr (BranchAddr),
    .InstrIn    (InstrIn),
    .InstrAddr  (InstrAddr),
    .InstrID    (InstrID),
    .PCPlus4ID  (PCPlus4ID),
    .ValidID    (ValidID),
    .FetchCount (FetchCount),
    .StallCount (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: one jump word at 0xC, otherwise an address-tagged pattern.
  always_comb begin
    InstrIn = 32'h2000_0000 | InstrAddr;
    if (InstrAddr == 32'h0000_000C) InstrIn = 32'h0800_0040;
  end

  task automatic step(input logic pcw, input logic ifw, input logic [1:0] sel,
                      input logic [31:0] br);
    PC_Write   = pcw;
    IF_Write   = ifw;
    addrSel    = sel;
    BranchAddr = br;
    @(posedge Clk);
    #1;
    if (Rst) begin
      if (ifw) exp_fetch = exp_fetch + 32'd1;
      if (!pcw && !ifw) exp_stall = exp_stall + 32'd1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; PC_Write = 1'b1; IF_Write = 1'b1; addrSel = 2'b00; BranchAddr = '0;
    exp_fetch = '0; exp_stall = '0;
    @(posedge Clk); #1;
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID, ValidID} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got pc=%h id=%h p4=%h v=%b want 0/0/0/0",
               InstrAddr, InstrID, PCPlus4ID, ValidID);
    end
    tests++;
    if ({FetchCount, StallCount} !== 64'h0) begin
      fails++;
      $display("FAIL reset_counters: got %h/%h want 0/0", FetchCount, StallCount);
    end
    Rst = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] exp_instr;
      step(1'b1, 1'b1, 2'b00, 32'h0);
      exp_instr = (i == 4) ? 32'h0800_0040 : (32'h2000_0000 | (32'(i - 1) * 4));
      tests++;
      if ({InstrAddr, InstrID, PCPlus4ID, ValidID} !== {32'(i) * 4, exp_instr, 32'(i) * 4, 1'b1}) begin
        fails++;
        $display("FAIL seq_fetch_%0d: got pc=%h id=%h p4=%h v=%b want %h/%h/%h/1",
                 i, InstrAddr, InstrID, PCPlus4ID, ValidID, 32'(i) * 4, exp_instr, 32'(i) * 4);
      end
    end
    tests++;
    if (FetchCount !== (c_CNT_EN ? exp_fetch : 32'h0)) begin
      fails++;
      $display("FAIL seq_fetch_count: got %h want %h", FetchCount, c_CNT_EN ? exp_fetch : 32'h0);
    end
  endtask

  task automatic test_jump();
    step(1'b1, 1'b0, 2'b01, 32'h0000_0500);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID, ValidID} !== {32'h100, 32'h0800_0040, 32'h10, 1'b1}) begin
      fails++;
      $display("FAIL jump_redirect: got pc=%h id=%h p4=%h v=%b want 100/08000040/10/1",
               InstrAddr, InstrID, PCPlus4ID, ValidID);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 1'b1, 2'b10, 32'h0000_0203);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID} !== {32'h200, 32'h2000_0100, 32'h104}) begin
      fails++;
      $display("FAIL branch_target: got pc=%h id=%h p4=%h want 200/20000100/104",
               InstrAddr, InstrID, PCPlus4ID);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b1, 2'b10, 32'h0000_0020);
    tests++;
    if (InstrAddr !== 32'h20) begin
      fails++;
      $display("FAIL stall_setup: got pc=%h want 20", InstrAddr);
    end
    step(1'b0, 1'b0, 2'b00, 32'h0);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID} !== {32'h20, 32'h2000_0200, 32'h204}) begin
      fails++;
      $display("FAIL stall_hold: got pc=%h id=%h p4=%h want 20/20000200/204",
               InstrAddr, InstrID, PCPlus4ID);
    end
    tests++;
    if ({FetchCount, StallCount} !== (c_CNT_EN ? {exp_fetch, exp_stall} : 64'h0)) begin
      fails++;
      $display("FAIL stall_counters: got %h/%h want %h/%h", FetchCount, StallCount,
               c_CNT_EN ? exp_fetch : 32'h0, c_CNT_EN ? exp_stall : 32'h0);
    end
  endtask

  task automatic test_refetch();
    step(1'b0, 1'b1, 2'b01, 32'h0);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID} !== {32'h20, 32'h2000_0020, 32'h24}) begin
      fails++;
      $display("FAIL refetch: got pc=%h id=%h p4=%h want 20/20000020/24",
               InstrAddr, InstrID, PCPlus4ID);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF);
    tests++;
    if (InstrAddr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL branch_align: got pc=%h want fffffffc", InstrAddr);
    end
    step(1'b1, 1'b1, 2'b00, 32'h0000_0300);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      fails++;
      $display("FAIL wrap_sel00: got pc=%h id=%h p4=%h want 0/fffffffc/0",
               InstrAddr, InstrID, PCPlus4ID);
    end
    step(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 2'b11, 32'h0000_0300);
    tests++;
    if (InstrAddr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_sel11: got pc=%h want 0", InstrAddr);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 2'b10, 32'h0000_0040);
    step(1'b0, 1'b0, 2'b00, 32'h0);
    tests++;
    if ({FetchCount, StallCount} !== (c_CNT_EN ? {exp_fetch, exp_stall} : 64'h0)) begin
      fails++;
      $display("FAIL pre_reset_counters: got %h/%h want %h/%h", FetchCount, StallCount,
               c_CNT_EN ? exp_fetch : 32'h0, c_CNT_EN ? exp_stall : 32'h0);
    end
    #2 Rst = 1'b0;
    #1;
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID, ValidID, FetchCount, StallCount} !==
        {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL async_reset: got pc=%h id=%h p4=%h v=%b fc=%h sc=%h want all 0",
               InstrAddr, InstrID, PCPlus4ID, ValidID, FetchCount, StallCount);
    end
    step(1'b1, 1'b1, 2'b01, 32'h0);
    tests++;
    if ({InstrAddr, ValidID} !== {32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold: got pc=%h v=%b want 0/0", InstrAddr, ValidID);
    end
    #2 Rst = 1'b1;
    exp_fetch = '0; exp_stall = '0;
    step(1'b1, 1'b1, 2'b00, 32'h0);
    tests++;
    if ({InstrAddr, InstrID, PCPlus4ID, ValidID} !== {32'h4, 32'h2000_0000, 32'h4, 1'b1}) begin
      fails++;
      $display("FAIL post_reset_fetch: got pc=%h id=%h p4=%h v=%b want 4/20000000/4/1",
               InstrAddr, InstrID, PCPlus4ID, ValidID);
    end
    tests++;
    if (FetchCount !== (c_CNT_EN ? 32'h1 : 32'h0)) begin
      fails++;
      $display("FAIL post_reset_count: got %h want %h", FetchCount, c_CNT_EN ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall();
    test_refetch();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
